// File: rtl/tj_pkg.sv
// rtl/tj_pkg.sv - shared types and constants for trojan benchmark blocks
package tj_pkg;

  typedef enum logic [1:0] {
    TJ_IDLE  = 2'd0,
    TJ_COUNT = 2'd1,
    TJ_FIRE  = 2'd2
  } tj_state_t;

  localparam int TJ_PAYLOAD_XOR = 0;
  localparam int TJ_PAYLOAD_OR  = 1;

endpackage

// File: rtl/tj_trigger_fsm.sv
// rtl/tj_trigger_fsm.sv - rare-pattern sequence trigger with payload window
module tj_trigger_fsm
  import tj_pkg::*;
#(
  parameter int TRIG_COUNT     = 4,
  parameter int PAYLOAD_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic match,
  output logic corrupt_now
);

  localparam int TC_W = $clog2(TRIG_COUNT + 1);
  localparam int PC_W = $clog2(PAYLOAD_CYCLES + 1);

  tj_state_t       state_q;
  logic [TC_W-1:0] cnt_q;
  logic [PC_W-1:0] pay_q;

  // Idle cycles never touch state: gaps neither break a sequence nor consume payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TJ_IDLE;
      cnt_q   <= '0;
      pay_q   <= '0;
    end else if (in_valid) begin
      case (state_q)
        TJ_IDLE: begin
          if (match) begin
            if (TRIG_COUNT == 1) begin
              state_q <= TJ_FIRE;
              pay_q   <= PC_W'(PAYLOAD_CYCLES);
            end else begin
              state_q <= TJ_COUNT;
              cnt_q   <= TC_W'(1);
            end
          end
        end
        TJ_COUNT: begin
          if (!match) begin
            state_q <= TJ_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == TC_W'(TRIG_COUNT - 1)) begin
            state_q <= TJ_FIRE;
            cnt_q   <= '0;
            pay_q   <= PC_W'(PAYLOAD_CYCLES);
          end else begin
            cnt_q <= cnt_q + TC_W'(1);
          end
        end
        TJ_FIRE: begin
          pay_q <= pay_q - PC_W'(1);
          if (pay_q == PC_W'(1)) begin
            state_q <= TJ_IDLE;
          end
        end
        default: begin
          state_q <= TJ_IDLE;
          cnt_q   <= '0;
          pay_q   <= '0;
        end
      endcase
    end
  end

  assign corrupt_now = in_valid && (state_q == TJ_FIRE);

endmodule

// File: rtl/seq_trojan_circuit.sv
// rtl/seq_trojan_circuit.sv - registered bitwise datapath with optional sequential trojan on h
module seq_trojan_circuit
  import tj_pkg::*;
#(
  parameter int               WIDTH          = 8,
  parameter int               TROJAN_EN      = 1,
  parameter logic [WIDTH-1:0] TRIG_PATTERN   = '1,
  parameter int               TRIG_COUNT     = 4,
  parameter int               PAYLOAD_CYCLES = 2,
  parameter int               PAYLOAD_MODE   = TJ_PAYLOAD_XOR,
  parameter logic [WIDTH-1:0] PAYLOAD_MASK   = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             out_valid,
  output logic [WIDTH-1:0] e,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] h,
  output logic             trojan_active
);

  if (TRIG_COUNT < 1 || PAYLOAD_CYCLES < 1 || PAYLOAD_MODE < 0 || PAYLOAD_MODE > 1) begin : g_bad_params
    $error("seq_trojan_circuit: illegal TRIG_COUNT/PAYLOAD_CYCLES/PAYLOAD_MODE");
  end

  logic             corrupt_now;
  logic [WIDTH-1:0] golden;
  logic             out_valid_q, trojan_active_q, trojan_active_d;
  logic [WIDTH-1:0] e_q, f_q, g_q, h_q;
  logic [WIDTH-1:0] e_d, f_d, g_d, h_d;

  if (TROJAN_EN != 0) begin : g_trojan
    logic match;
    assign match = in_valid && ((a & ~c) == TRIG_PATTERN);

    tj_trigger_fsm #(
      .TRIG_COUNT    (TRIG_COUNT),
      .PAYLOAD_CYCLES(PAYLOAD_CYCLES)
    ) u_trigger (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .match      (match),
      .corrupt_now(corrupt_now)
    );
  end else begin : g_golden
    assign corrupt_now = 1'b0;
  end

  // Deliberately unsimplified host logic; it reduces to a & b & c.
  assign golden = ((a & b) | ((a | c) & ~c)) & c;

  always_comb begin
    e_d             = e_q;
    f_d             = f_q;
    g_d             = g_q;
    h_d             = h_q;
    trojan_active_d = corrupt_now;
    if (in_valid) begin
      e_d = a & b;
      f_d = a | c;
      g_d = ~c;
      h_d = golden;
      if (corrupt_now) begin
        h_d = (PAYLOAD_MODE == TJ_PAYLOAD_OR) ? (golden | PAYLOAD_MASK) : (golden ^ PAYLOAD_MASK);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q     <= 1'b0;
      trojan_active_q <= 1'b0;
      e_q             <= '0;
      f_q             <= '0;
      g_q             <= '0;
      h_q             <= '0;
    end else begin
      out_valid_q     <= in_valid;
      trojan_active_q <= trojan_active_d;
      e_q             <= e_d;
      f_q             <= f_d;
      g_q             <= g_d;
      h_q             <= h_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign trojan_active = trojan_active_q;
  assign e             = e_q;
  assign f             = f_q;
  assign g             = g_q;
  assign h             = h_q;

endmodule

// File: tb/tb_seq_trojan_circuit.sv
// tb/tb_seq_trojan_circuit.sv - directed self-checking bench for seq_trojan_circuit
module tb_seq_trojan_circuit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] a = '0, b = '0, c = '0;

  logic       ov_m, ta_m, ov_o, ta_o, ov_g, ta_g;
  logic [7:0] e_m, f_m, g_m, h_m;
  logic [7:0] e_o, f_o, g_o, h_o;
  logic [7:0] e_g, f_g, g_g, h_g;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_trojan_circuit #(.WIDTH(8), .TROJAN_EN(1), .TRIG_COUNT(3), .PAYLOAD_CYCLES(2),
                       .PAYLOAD_MODE(0), .PAYLOAD_MASK(8'h01)) dut_xor (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .c(c),
    .out_valid(ov_m), .e(e_m), .f(f_m), .g(g_m), .h(h_m), .trojan_active(ta_m));

  seq_trojan_circuit #(.WIDTH(8), .TROJAN_EN(1), .TRIG_COUNT(3), .PAYLOAD_CYCLES(2),
                       .PAYLOAD_MODE(1), .PAYLOAD_MASK(8'h80)) dut_or (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .c(c),
    .out_valid(ov_o), .e(e_o), .f(f_o), .g(g_o), .h(h_o), .trojan_active(ta_o));

  seq_trojan_circuit #(.WIDTH(8), .TROJAN_EN(0), .TRIG_COUNT(3), .PAYLOAD_CYCLES(2),
                       .PAYLOAD_MODE(0), .PAYLOAD_MASK(8'h01)) dut_gold (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .c(c),
    .out_valid(ov_g), .e(e_g), .f(f_g), .g(g_g), .h(h_g), .trojan_active(ta_g));

  task automatic beat(input logic v, input logic [7:0] av, input logic [7:0] bv, input logic [7:0] cv);
    in_valid = v;
    a = av;
    b = bv;
    c = cv;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    beat(1'b1, 8'hFF, 8'hFF, 8'hFF);
    checks++;
    if ({ov_m, ta_m, e_m, f_m, g_m, h_m} !== 34'd0) begin
      errors++;
      $display("FAIL reset_xor: got ov=%b ta=%b e=%h f=%h g=%h h=%h, want all 0", ov_m, ta_m, e_m, f_m, g_m, h_m);
    end
    checks++;
    if ({ov_o, ta_o, h_o, ov_g, ta_g, h_g} !== 20'd0) begin
      errors++;
      $display("FAIL reset_variants: got or(ov=%b ta=%b h=%h) gold(ov=%b ta=%b h=%h), want all 0", ov_o, ta_o, h_o, ov_g, ta_g, h_g);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_golden_datapath();
    beat(1'b1, 8'hF0, 8'hFF, 8'h0F);
    checks++;
    if ({ov_m, e_m, f_m, g_m, h_m, ta_m} !== {1'b1, 8'hF0, 8'hFF, 8'hF0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL datapath: got ov=%b e=%h f=%h g=%h h=%h ta=%b, want ov=1 e=f0 f=ff g=f0 h=00 ta=0", ov_m, e_m, f_m, g_m, h_m, ta_m);
    end
    beat(1'b0, 8'h12, 8'h34, 8'h56);
    checks++;
    if ({ov_m, e_m, f_m, g_m, h_m} !== {1'b0, 8'hF0, 8'hFF, 8'hF0, 8'h00}) begin
      errors++;
      $display("FAIL hold_idle: got ov=%b e=%h f=%h g=%h h=%h, want ov=0 e=f0 f=ff g=f0 h=00", ov_m, e_m, f_m, g_m, h_m);
    end
  endtask

  task automatic test_trigger_payload();
    logic [7:0] exp_h [3] = '{8'h0E, 8'h0E, 8'h0F};
    logic       exp_ta[3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      beat(1'b1, 8'hFF, 8'hFF, 8'h00);
      checks++;
      if (h_m !== 8'h00 || ta_m !== 1'b0) begin
        errors++;
        $display("FAIL trigger_beat%0d: got h=%h ta=%b, want h=00 ta=0", i, h_m, ta_m);
      end
    end
    for (int i = 0; i < 3; i++) begin
      beat(1'b1, 8'h0F, 8'h0F, 8'h0F);
      checks++;
      if (h_m !== exp_h[i] || ta_m !== exp_ta[i] || e_m !== 8'h0F || g_m !== 8'hF0) begin
        errors++;
        $display("FAIL payload%0d: got h=%h ta=%b e=%h g=%h, want h=%h ta=%b e=0f g=f0", i, h_m, ta_m, e_m, g_m, exp_h[i], exp_ta[i]);
      end
      checks++;
      if (h_g !== 8'h0F || ta_g !== 1'b0) begin
        errors++;
        $display("FAIL golden_build%0d: got h=%h ta=%b, want h=0f ta=0", i, h_g, ta_g);
      end
    end
  endtask

  task automatic test_broken_sequence();
    logic [7:0] seq_a[5] = '{8'hFF, 8'hFF, 8'h0F, 8'hFF, 8'hFF};
    logic [7:0] seq_c[5] = '{8'h00, 8'h00, 8'h0F, 8'h00, 8'h00};
    for (int i = 0; i < 5; i++) begin
      beat(1'b1, seq_a[i], seq_a[i], seq_c[i]);
      checks++;
      if (ta_m !== 1'b0) begin
        errors++;
        $display("FAIL broken_seq_beat%0d: got ta=%b, want 0", i, ta_m);
      end
    end
    beat(1'b1, 8'h0F, 8'h0F, 8'h0F);
    checks++;
    if (h_m !== 8'h0F || ta_m !== 1'b0) begin
      errors++;
      $display("FAIL broken_seq: got h=%h ta=%b, want h=0f ta=0", h_m, ta_m);
    end
  endtask

  task automatic test_gaps();
    beat(1'b1, 8'hFF, 8'hFF, 8'h00);
    for (int i = 0; i < 5; i++) begin
      beat(1'b0, 8'hFF, 8'hFF, 8'h00);
    end
    checks++;
    if (ov_m !== 1'b0 || h_m !== 8'h00 || e_m !== 8'hFF) begin
      errors++;
      $display("FAIL gap_hold: got ov=%b h=%h e=%h, want ov=0 h=00 e=ff", ov_m, h_m, e_m);
    end
    beat(1'b1, 8'hFF, 8'hFF, 8'h00);
    beat(1'b1, 8'hFF, 8'hFF, 8'h00);
    beat(1'b0, 8'h0F, 8'h0F, 8'h0F);
    beat(1'b1, 8'h0F, 8'h0F, 8'h0F);
    checks++;
    if (h_m !== 8'h0E || ta_m !== 1'b1) begin
      errors++;
      $display("FAIL gaps_fire: got h=%h ta=%b, want h=0e ta=1", h_m, ta_m);
    end
    beat(1'b1, 8'h0F, 8'h0F, 8'h0F);
    beat(1'b1, 8'h0F, 8'h0F, 8'h0F);
    checks++;
    if (h_m !== 8'h0F || ta_m !== 1'b0) begin
      errors++;
      $display("FAIL gaps_drain: got h=%h ta=%b, want h=0f ta=0", h_m, ta_m);
    end
  endtask

  task automatic test_reset_mid_fire();
    for (int i = 0; i < 3; i++) beat(1'b1, 8'hFF, 8'hFF, 8'h00);
    beat(1'b1, 8'h0F, 8'h0F, 8'h0F);
    checks++;
    if (h_m !== 8'h0E || ta_m !== 1'b1) begin
      errors++;
      $display("FAIL prereset_fire: got h=%h ta=%b, want h=0e ta=1", h_m, ta_m);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ov_m, ta_m, e_m, f_m, g_m, h_m} !== 34'd0) begin
      errors++;
      $display("FAIL async_reset: got ov=%b ta=%b e=%h f=%h g=%h h=%h, want all 0", ov_m, ta_m, e_m, f_m, g_m, h_m);
    end
    @(negedge clk);
    rst_n = 1'b1;
    beat(1'b1, 8'h0F, 8'h0F, 8'h0F);
    checks++;
    if (h_m !== 8'h0F || ta_m !== 1'b0) begin
      errors++;
      $display("FAIL postreset_clean: got h=%h ta=%b, want h=0f ta=0", h_m, ta_m);
    end
    beat(1'b1, 8'hFF, 8'hFF, 8'h00);
    beat(1'b1, 8'hFF, 8'hFF, 8'h00);
    beat(1'b1, 8'h0F, 8'h0F, 8'h0F);
    checks++;
    if (h_m !== 8'h0F || ta_m !== 1'b0) begin
      errors++;
      $display("FAIL two_matches_no_fire: got h=%h ta=%b, want h=0f ta=0", h_m, ta_m);
    end
    for (int i = 0; i < 3; i++) beat(1'b1, 8'hFF, 8'hFF, 8'h00);
    beat(1'b1, 8'h0F, 8'h0F, 8'h0F);
    checks++;
    if (h_m !== 8'h0E || ta_m !== 1'b1) begin
      errors++;
      $display("FAIL refire: got h=%h ta=%b, want h=0e ta=1", h_m, ta_m);
    end
    beat(1'b1, 8'h0F, 8'h0F, 8'h0F);
  endtask

  task automatic test_or_mode();
    for (int i = 0; i < 3; i++) beat(1'b1, 8'hFF, 8'hFF, 8'h00);
    beat(1'b1, 8'h8F, 8'h8F, 8'h8F);
    checks++;
    if (h_o !== 8'h8F || ta_o !== 1'b1) begin
      errors++;
      $display("FAIL or_no_change: got h=%h ta=%b, want h=8f ta=1", h_o, ta_o);
    end
    beat(1'b1, 8'h0F, 8'h0F, 8'h0F);
    checks++;
    if (h_o !== 8'h8F || ta_o !== 1'b1) begin
      errors++;
      $display("FAIL or_stuck: got h=%h ta=%b, want h=8f ta=1", h_o, ta_o);
    end
    checks++;
    if (h_g !== 8'h0F || ta_g !== 1'b0) begin
      errors++;
      $display("FAIL or_golden: got h=%h ta=%b, want h=0f ta=0", h_g, ta_g);
    end
    beat(1'b1, 8'h0F, 8'h0F, 8'h0F);
    checks++;
    if (h_o !== 8'h0F || ta_o !== 1'b0) begin
      errors++;
      $display("FAIL or_done: got h=%h ta=%b, want h=0f ta=0", h_o, ta_o);
    end
  endtask

  initial begin
    test_reset();
    test_golden_datapath();
    test_trigger_payload();
    test_broken_sequence();
    test_gaps();
    test_reset_mid_fire();
    test_or_mode();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
